// File: rtl/i2cm_seq_pkg.sv
// Register map, CR/SR bit positions, response codes and state encoding for the
// I2C master command sequencer.
package i2cm_seq_pkg;

  localparam logic [2:0] REG_PRERLO = 3'd0;
  localparam logic [2:0] REG_PRERHI = 3'd1;
  localparam logic [2:0] REG_CTR    = 3'd2;
  localparam logic [2:0] REG_TXR    = 3'd3;
  localparam logic [2:0] REG_RXR    = 3'd3;
  localparam logic [2:0] REG_CR     = 3'd4;
  localparam logic [2:0] REG_SR     = 3'd4;

  localparam int unsigned CR_STA   = 7;
  localparam int unsigned CR_STO   = 6;
  localparam int unsigned CR_RD    = 5;
  localparam int unsigned CR_WR    = 4;
  localparam int unsigned CR_ACK   = 3;
  localparam int unsigned SR_RXACK = 7;
  localparam int unsigned SR_AL    = 5;
  localparam int unsigned SR_TIP   = 1;
  localparam int unsigned CTR_EN   = 7;

  localparam logic [7:0] CR_START_WR       = 8'((1 << CR_STA) | (1 << CR_WR));
  localparam logic [7:0] CR_WRITE          = 8'(1 << CR_WR);
  localparam logic [7:0] CR_WRITE_STOP     = 8'((1 << CR_STO) | (1 << CR_WR));
  localparam logic [7:0] CR_READ_NACK_STOP = 8'((1 << CR_STO) | (1 << CR_RD) | (1 << CR_ACK));
  localparam logic [7:0] CR_STOP           = 8'(1 << CR_STO);
  localparam logic [7:0] CTR_CORE_EN       = 8'(1 << CTR_EN);

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_AL   = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef logic [3:0] seq_state_t;

  localparam seq_state_t S_INIT_PL   = 4'd0;
  localparam seq_state_t S_INIT_PH   = 4'd1;
  localparam seq_state_t S_INIT_CTR  = 4'd2;
  localparam seq_state_t S_IDLE      = 4'd3;
  localparam seq_state_t S_WR_TXR    = 4'd4;
  localparam seq_state_t S_WR_CR     = 4'd5;
  localparam seq_state_t S_POLL_GAP  = 4'd6;
  localparam seq_state_t S_RD_SR     = 4'd7;
  localparam seq_state_t S_CHK       = 4'd8;
  localparam seq_state_t S_RD_RXR    = 4'd9;
  localparam seq_state_t S_STOP_CR   = 4'd10;
  localparam seq_state_t S_STOP_POLL = 4'd11;
  localparam seq_state_t S_RESP      = 4'd12;

  // Byte 3 exists only for reads and has no TXR write (it is the data receive).
  function automatic logic [7:0] txr_for_byte(input logic [1:0] idx, input logic rd,
                                              input logic [6:0] dev, input logic [7:0] rg,
                                              input logic [7:0] wdata);
    case (idx)
      2'd0:    txr_for_byte = {dev, 1'b0};
      2'd1:    txr_for_byte = rg;
      2'd2:    txr_for_byte = rd ? {dev, 1'b1} : wdata;
      default: txr_for_byte = '0;
    endcase
  endfunction

  function automatic logic [7:0] cr_for_byte(input logic [1:0] idx, input logic rd);
    case (idx)
      2'd0:    cr_for_byte = CR_START_WR;
      2'd1:    cr_for_byte = CR_WRITE;
      2'd2:    cr_for_byte = rd ? CR_START_WR : CR_WRITE_STOP;
      default: cr_for_byte = CR_READ_NACK_STOP;
    endcase
  endfunction

endpackage

// File: rtl/i2cm_seq_bus.sv
// Single-access register bus engine: one access outstanding, fields held stable
// from strobe assertion through m_ack, read data captured on acknowledge.
module i2cm_seq_bus (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       wr_i,
  input  logic [2:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       m_cs_o,
  output logic       m_wr_o,
  output logic [2:0] m_addr_o,
  output logic [7:0] m_wdata_o,
  input  logic [7:0] m_rdata_i,
  input  logic       m_ack_i
);

  logic       cs_q;
  logic       wr_q;
  logic [2:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (!cs_q) begin
      if (start_i) begin
        cs_q    <= 1'b1;
        wr_q    <= wr_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end else if (m_ack_i) begin
      cs_q    <= 1'b0;
      rdata_q <= m_rdata_i;
    end
  end

  assign busy_o    = cs_q;
  assign done_o    = cs_q & m_ack_i;
  assign rdata_o   = rdata_q;
  assign m_cs_o    = cs_q;
  assign m_wr_o    = wr_q;
  assign m_addr_o  = addr_q;
  assign m_wdata_o = wdata_q;

endmodule

// File: rtl/i2cm_cmd_seq.sv
// I2C master command sequencer: turns one register read/write request into the
// TXR/CR write and SR poll sequence. Optional SR-poll timeout: I2CM_SEQ_TIMEOUT_EN.
module i2cm_cmd_seq #(
  parameter logic [15:0] PRESCALE   = 16'h0063,
  parameter int unsigned POLL_GAP   = 4,
  parameter logic [19:0] TMO_CYCLES = 20'hFFFFF
) (
  input  logic       app_clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [1:0] rsp_err,
  output logic [7:0] rsp_rdata,
  output logic       m_cs,
  output logic       m_wr,
  output logic [2:0] m_addr,
  output logic [7:0] m_wdata,
  input  logic [7:0] m_rdata,
  input  logic       m_ack
);

  import i2cm_seq_pkg::*;

  localparam logic [4:0] GAP_LAST     = 5'(POLL_GAP);
  localparam seq_state_t S_POLL_ENTRY = (POLL_GAP == 0) ? S_RD_SR : S_POLL_GAP;

  seq_state_t state_q, state_d;
  logic [1:0] byte_q, byte_d;
  logic [3:0] gap_q, gap_d;
  logic [1:0] err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rd_q, rd_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;

  logic       acc_req;
  logic       acc_wr;
  logic [2:0] acc_addr;
  logic [7:0] acc_wdata;
  logic       bus_busy;
  logic       bus_done;
  logic [7:0] bus_rdata;
  logic       last_byte;
  logic       tmo_hit;
  logic       unused_sr_bits;

  i2cm_seq_bus u_bus (
    .clk_i     (app_clk),
    .rst_n_i   (reset_n),
    .start_i   (acc_req & ~bus_busy),
    .wr_i      (acc_wr),
    .addr_i    (acc_addr),
    .wdata_i   (acc_wdata),
    .busy_o    (bus_busy),
    .done_o    (bus_done),
    .rdata_o   (bus_rdata),
    .m_cs_o    (m_cs),
    .m_wr_o    (m_wr),
    .m_addr_o  (m_addr),
    .m_wdata_o (m_wdata),
    .m_rdata_i (m_rdata),
    .m_ack_i   (m_ack)
  );

  assign unused_sr_bits = ^{bus_rdata[6], bus_rdata[4:2], bus_rdata[0]};

`ifdef I2CM_SEQ_TIMEOUT_EN
  logic [19:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q >= TMO_CYCLES);

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_WR_CR && bus_done) begin
      tmo_d = '0;
    end else if ((state_q == S_POLL_GAP || state_q == S_RD_SR) && !tmo_hit) begin
      tmo_d = tmo_q + 20'd1;
    end
  end

  always_ff @(posedge app_clk) begin
    if (!reset_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TMO_CYCLES;
`endif

  assign last_byte = rd_q ? (byte_q == 2'd3) : (byte_q == 2'd2);

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    gap_d     = gap_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rd_d      = rd_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    acc_req   = 1'b0;
    acc_wr    = 1'b1;
    acc_addr  = REG_CR;
    acc_wdata = '0;
    case (state_q)
      S_INIT_PL: begin
        acc_req   = 1'b1;
        acc_addr  = REG_PRERLO;
        acc_wdata = PRESCALE[7:0];
        if (bus_done) state_d = S_INIT_PH;
      end
      S_INIT_PH: begin
        acc_req   = 1'b1;
        acc_addr  = REG_PRERHI;
        acc_wdata = PRESCALE[15:8];
        if (bus_done) state_d = S_INIT_CTR;
      end
      S_INIT_CTR: begin
        acc_req   = 1'b1;
        acc_addr  = REG_CTR;
        acc_wdata = CTR_CORE_EN;
        if (bus_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid) begin
          rd_d    = req_rd;
          dev_d   = req_dev;
          reg_d   = req_reg;
          wdata_d = req_wdata;
          byte_d  = '0;
          err_d   = ERR_OK;
          state_d = S_WR_TXR;
        end
      end
      S_WR_TXR: begin
        acc_req   = 1'b1;
        acc_addr  = REG_TXR;
        acc_wdata = txr_for_byte(byte_q, rd_q, dev_q, reg_q, wdata_q);
        if (bus_done) state_d = S_WR_CR;
      end
      S_WR_CR: begin
        acc_req   = 1'b1;
        acc_addr  = REG_CR;
        acc_wdata = cr_for_byte(byte_q, rd_q);
        if (bus_done) begin
          gap_d   = '0;
          state_d = S_POLL_ENTRY;
        end
      end
      S_POLL_GAP: begin
        if (tmo_hit) begin
          err_d   = ERR_TMO;
          state_d = S_STOP_CR;
        end else if (({1'b0, gap_q} + 5'd1) == GAP_LAST) begin
          state_d = S_RD_SR;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_RD_SR: begin
        acc_req  = 1'b1;
        acc_wr   = 1'b0;
        acc_addr = REG_SR;
        if (bus_done) state_d = S_CHK;
      end
      S_CHK: begin
        // On the read data byte RxACK reflects our own NACK, so it is not an error.
        if (bus_rdata[SR_TIP]) begin
          if (tmo_hit) begin
            err_d   = ERR_TMO;
            state_d = S_STOP_CR;
          end else begin
            gap_d   = '0;
            state_d = S_POLL_ENTRY;
          end
        end else if (bus_rdata[SR_AL]) begin
          err_d   = ERR_AL;
          state_d = S_RESP;
        end else if (bus_rdata[SR_RXACK] && !(rd_q && byte_q == 2'd3)) begin
          err_d   = ERR_NACK;
          state_d = S_STOP_CR;
        end else if (last_byte) begin
          state_d = rd_q ? S_RD_RXR : S_RESP;
        end else begin
          byte_d  = byte_q + 2'd1;
          state_d = (rd_q && byte_q == 2'd2) ? S_WR_CR : S_WR_TXR;
        end
      end
      S_RD_RXR: begin
        acc_req  = 1'b1;
        acc_wr   = 1'b0;
        acc_addr = REG_RXR;
        if (bus_done) begin
          rdata_d = m_rdata;
          state_d = S_RESP;
        end
      end
      S_STOP_CR: begin
        acc_req   = 1'b1;
        acc_addr  = REG_CR;
        acc_wdata = CR_STOP;
        if (bus_done) state_d = (err_q == ERR_TMO) ? S_RESP : S_STOP_POLL;
      end
      S_STOP_POLL: begin
        acc_req  = 1'b1;
        acc_wr   = 1'b0;
        acc_addr = REG_SR;
        if (bus_done && !m_rdata[SR_TIP]) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT_PL;
      end
    endcase
  end

  always_ff @(posedge app_clk) begin
    if (!reset_n) begin
      state_q <= S_INIT_PL;
      byte_q  <= '0;
      gap_q   <= '0;
      err_q   <= ERR_OK;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_i2cm_cmd_seq.sv
// Bench for i2cm_cmd_seq: behavioural I2C master register model, vector table,
// randomized requests, timeout and mid-sequence reset sequences.
module tb_i2cm_cmd_seq;

  localparam logic [15:0] PRESCALE = 16'h0063;
  localparam int unsigned POLL_GAP = 4;
  localparam logic [19:0] TMO      = 20'd64;
  localparam int          NONE     = 9;

  logic       app_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rd = 1'b0;
  logic [6:0] req_dev = '0;
  logic [7:0] req_reg = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [1:0] rsp_err;
  logic [7:0] rsp_rdata;
  logic       m_cs;
  logic       m_wr;
  logic [2:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;
  logic       m_ack;

  always #5 app_clk = ~app_clk;

  i2cm_cmd_seq #(.PRESCALE(PRESCALE), .POLL_GAP(POLL_GAP), .TMO_CYCLES(TMO)) dut (
    .app_clk(app_clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .m_cs(m_cs), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Register model state: write log ({addr,data}) and SR behaviour per CR write.
  logic [15:0] wlog[$];
  logic [15:0] expq[$];
  int          cr_num;
  int          nack_idx = NONE;
  int          al_idx = NONE;
  int          stuck_idx = NONE;
  bit          stuck = 1'b0;
  int          tip_left = 0;
  logic [7:0]  final_sr = 8'h00;
  logic [7:0]  rxr_val = 8'h00;

  initial begin : slave
    int lat;
    bit act;
    logic [11:0] seen;
    m_ack = 1'b0;
    m_rdata = '0;
    act = 1'b0;
    lat = 0;
    seen = '0;
    forever begin
      @(posedge app_clk);
      #1;
      if (!reset_n) begin
        m_ack = 1'b0;
        act = 1'b0;
      end else if (m_ack) begin
        m_ack = 1'b0;
        check("cs_drop_after_ack", {31'b0, m_cs}, 32'd0);
      end else if (m_cs) begin
        if (!act) begin
          act = 1'b1;
          lat = $urandom_range(0, 3);
          seen = {m_wr, m_addr, m_wdata};
        end
        if (lat == 0) begin
          check("bus_stable", {20'b0, m_wr, m_addr, m_wdata}, {20'b0, seen});
          act = 1'b0;
          m_rdata = 8'($urandom);
          if (m_wr) begin
            wlog.push_back({5'b0, m_addr, m_wdata});
            if (m_addr == 3'd4) begin
              tip_left = $urandom_range(0, 3);
              if (m_wdata == 8'h40) begin
                final_sr = 8'h00;
              end else begin
                final_sr = (cr_num == nack_idx) ? 8'h80 : (cr_num == al_idx) ? 8'h20 : 8'h00;
                if (cr_num == stuck_idx) stuck = 1'b1;
                cr_num++;
              end
            end
          end else if (m_addr == 3'd4) begin
            if (stuck || tip_left > 0) begin
              m_rdata = 8'h02;
              if (tip_left > 0) tip_left--;
            end else begin
              m_rdata = final_sr;
            end
          end else if (m_addr == 3'd3) begin
            m_rdata = rxr_val;
          end
          m_ack = 1'b1;
        end else begin
          lat--;
        end
      end
    end
  end

  // Expected writes from the transaction rules: per byte TXR (if any) then CR;
  // AL ends the transaction, NACK appends a STOP.
  task automatic build_exp(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input int nack, input int al,
                           output logic [1:0] err);
    logic [7:0] txr[4];
    logic [7:0] cr[4];
    int n;
    txr[0] = {dev, 1'b0};
    txr[1] = rg;
    txr[2] = rd ? {dev, 1'b1} : wd;
    txr[3] = 8'h00;
    cr[0] = 8'h90;
    cr[1] = 8'h10;
    cr[2] = rd ? 8'h90 : 8'h50;
    cr[3] = 8'h68;
    n = rd ? 4 : 3;
    expq.delete();
    err = 2'd0;
    for (int i = 0; i < n; i++) begin
      if (i < 3) expq.push_back({13'd3, txr[i]});
      expq.push_back({13'd4, cr[i]});
      if (i == al) begin
        err = 2'd2;
        break;
      end
      if (i == nack) begin
        expq.push_back({13'd4, 8'h40});
        err = 2'd1;
        break;
      end
    end
  endtask

  task automatic compare_log(input string name);
    check({name, "_len"}, wlog.size(), expq.size());
    for (int i = 0; i < wlog.size() && i < expq.size(); i++) begin
      check({name, "_write"}, {16'b0, wlog[i]}, {16'b0, expq[i]});
    end
  endtask

  task automatic run_req(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [7:0] rxr, input int nack,
                         input int al, input int stk, input int budget,
                         output bit got, output logic [1:0] err, output logic [7:0] rdata,
                         output int cycles);
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge app_clk);
    check("req_ready_wait", {31'b0, req_ready}, 32'd1);
    wlog.delete();
    cr_num = 0;
    nack_idx = nack;
    al_idx = al;
    stuck_idx = stk;
    stuck = 1'b0;
    rxr_val = rxr;
    req_rd = rd;
    req_dev = dev;
    req_reg = rg;
    req_wdata = wd;
    req_valid = 1'b1;
    @(negedge app_clk);
    req_valid = 1'b0;
    req_rd = 1'($urandom);
    req_dev = 7'($urandom);
    req_reg = 8'($urandom);
    req_wdata = 8'($urandom);
    got = 1'b0;
    err = '0;
    rdata = '0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        err = rsp_err;
        rdata = rsp_rdata;
        cycles = i;
        break;
      end
      @(negedge app_clk);
    end
    if (got) begin
      check("ready_low_in_resp", {31'b0, req_ready}, 32'd0);
      @(negedge app_clk);
      check("rsp_single_pulse", {31'b0, rsp_valid}, 32'd0);
      check("ready_after_resp", {31'b0, req_ready}, 32'd1);
    end
  endtask

  task automatic reset_and_init();
    reset_n = 1'b0;
    @(negedge app_clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {30'b0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
    check("rst_m_bus", {19'b0, m_cs, m_wr, m_addr, m_wdata}, 32'd0);
    @(negedge app_clk);
    @(negedge app_clk);
    wlog.delete();
    stuck = 1'b0;
    stuck_idx = NONE;
    reset_n = 1'b1;
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge app_clk);
    check("init_ready", {31'b0, req_ready}, 32'd1);
    expq.delete();
    expq.push_back({13'd0, PRESCALE[7:0]});
    expq.push_back({13'd1, PRESCALE[15:8]});
    expq.push_back({13'd2, 8'h80});
    compare_log("init");
  endtask

  typedef struct {
    bit         rd;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [7:0] rxr;
    int         nack;
    int         al;
    logic [1:0] err;
  } vec_t;

  vec_t vt[6];

  initial begin : main
    bit got;
    logic [1:0] err, eerr;
    logic [7:0] rdata;
    int cyc;

    vt[0] = '{rd: 1'b0, dev: 7'h50, rg: 8'h12, wd: 8'hA5, rxr: 8'h00, nack: NONE, al: NONE, err: 2'd0};
    vt[1] = '{rd: 1'b1, dev: 7'h50, rg: 8'h34, wd: 8'h00, rxr: 8'h5C, nack: NONE, al: NONE, err: 2'd0};
    vt[2] = '{rd: 1'b0, dev: 7'h50, rg: 8'h12, wd: 8'hA5, rxr: 8'h00, nack: 0,    al: NONE, err: 2'd1};
    vt[3] = '{rd: 1'b1, dev: 7'h21, rg: 8'h07, wd: 8'h00, rxr: 8'h3C, nack: NONE, al: 2,    err: 2'd2};
    vt[4] = '{rd: 1'b1, dev: 7'h7F, rg: 8'hFF, wd: 8'h00, rxr: 8'h11, nack: 1,    al: NONE, err: 2'd1};
    vt[5] = '{rd: 1'b0, dev: 7'h00, rg: 8'h00, wd: 8'hFF, rxr: 8'h00, nack: NONE, al: 0,    err: 2'd2};

    reset_and_init();

    foreach (vt[k]) begin
      build_exp(vt[k].rd, vt[k].dev, vt[k].rg, vt[k].wd, vt[k].nack, vt[k].al, eerr);
      run_req(vt[k].rd, vt[k].dev, vt[k].rg, vt[k].wd, vt[k].rxr, vt[k].nack, vt[k].al,
              NONE, 3000, got, err, rdata, cyc);
      check("vec_rsp_valid", {31'b0, got}, 32'd1);
      check("vec_rsp_err", {30'b0, err}, {30'b0, vt[k].err});
      if (vt[k].rd && vt[k].err == 2'd0) check("vec_rsp_rdata", {24'b0, rdata}, {24'b0, vt[k].rxr});
      compare_log("vec");
    end

    for (int r = 0; r < 30; r++) begin
      bit rd;
      int kind, nack, al;
      logic [6:0] dev;
      logic [7:0] rg, wd, rxr;
      rd = 1'($urandom);
      dev = 7'($urandom);
      rg = 8'($urandom);
      wd = 8'($urandom);
      rxr = 8'($urandom);
      kind = $urandom_range(0, 3);
      nack = NONE;
      al = NONE;
      if (kind == 2) nack = $urandom_range(0, 2);
      if (kind == 3) al = $urandom_range(0, rd ? 3 : 2);
      build_exp(rd, dev, rg, wd, nack, al, eerr);
      run_req(rd, dev, rg, wd, rxr, nack, al, NONE, 3000, got, err, rdata, cyc);
      check("rnd_rsp_valid", {31'b0, got}, 32'd1);
      check("rnd_rsp_err", {30'b0, err}, {30'b0, eerr});
      if (rd && eerr == 2'd0) check("rnd_rsp_rdata", {24'b0, rdata}, {24'b0, rxr});
      compare_log("rnd");
    end

    // TIP stuck on the address byte.
`ifdef I2CM_SEQ_TIMEOUT_EN
    run_req(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, NONE, NONE, 0, 3000, got, err, rdata, cyc);
    check("tmo_rsp_valid", {31'b0, got}, 32'd1);
    check("tmo_rsp_err", {30'b0, err}, 32'd3);
    check("tmo_not_early", {31'b0, (cyc >= 64)}, 32'd1);
    check("tmo_not_late", {31'b0, (cyc < 300)}, 32'd1);
    expq.delete();
    expq.push_back({13'd3, 8'hA0});
    expq.push_back({13'd4, 8'h90});
    expq.push_back({13'd4, 8'h40});
    compare_log("tmo");
`else
    run_req(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, NONE, NONE, 0, 600, got, err, rdata, cyc);
    check("stuck_no_rsp", {31'b0, got}, 32'd0);
    reset_and_init();
`endif

    // Reset while polling the third byte of a write.
    run_req(1'b0, 7'h2A, 8'h55, 8'hC3, 8'h00, NONE, NONE, 2, 400, got, err, rdata, cyc);
    check("third_poll_no_rsp", {31'b0, got}, 32'd0);
    check("third_poll_reached", cr_num, 32'd3);
    reset_and_init();

    build_exp(1'b1, 7'h50, 8'h34, 8'h00, NONE, NONE, eerr);
    run_req(1'b1, 7'h50, 8'h34, 8'h00, 8'h5C, NONE, NONE, NONE, 3000, got, err, rdata, cyc);
    check("post_rst_rsp_valid", {31'b0, got}, 32'd1);
    check("post_rst_rsp_err", {30'b0, err}, 32'd0);
    check("post_rst_rdata", {24'b0, rdata}, 32'h5C);
    compare_log("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
